vec3_normalize: RTL

- Normalises a signed Q8.24 3-vector for the ray marcher, e.g. ray directions and SDF gradient normals.
- Computes the squared length and hands it to the existing external `inv_sqrt` stage, which is downstream of this block and instantiated by the parent.
- Holds the vector components in a side FIFO while `inv_sqrt` runs, then scales each component by the returned 1/sqrt when the result arrives.
- Tolerates any fixed `inv_sqrt` latency, because pairing is by result order, not by a cycle count.

---
 rtl/raymarch_pkg.sv | 23 ++
 rtl/vec3_norm_fifo.sv | 58 +++++
 rtl/vec3_normalize.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/raymarch_pkg.sv
// Shared fixed-point types for the ray marcher: signed Q8.24 scalars and 3-vectors.
package raymarch_pkg;

    localparam int Q_WIDTH = 32;
    localparam int Q_FRAC  = 24;

    typedef logic signed [Q_WIDTH-1:0] q8_24_t;

    typedef struct packed {
        q8_24_t x;
        q8_24_t y;
        q8_24_t z;
    } vec3_t;

    localparam q8_24_t Q_MAX = 32'sh7FFF_FFFF;
    localparam q8_24_t Q_MIN = 32'sh8000_0000;

    // Saturation value chosen by the sign of the out-of-range result.
    function automatic q8_24_t q_sat(input logic negative);
        return negative ? Q_MIN : Q_MAX;
    endfunction

endpackage

// File: rtl/vec3_norm_fifo.sv
// Side FIFO that parks input vectors while inv_sqrt runs; empty pops are ignored.
module vec3_norm_fifo
    import raymarch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  vec3_t                    push_data,
    input  logic                     pop,
    output vec3_t                    head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    vec3_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH[AW:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_reg;

    // Head is read combinationally so the scale multiply lands in the pop cycle.
    assign head = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/vec3_normalize.sv
// Q8.24 3-vector normaliser around an external inv_sqrt stage, paired by result order.
// Define VEC3_NORM_SAT_EN to saturate sq_len and the outputs instead of wrapping.
module vec3_normalize
    import raymarch_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             in_ready,
    input  logic [WIDTH-1:0] vx,
    input  logic [WIDTH-1:0] vy,
    input  logic [WIDTH-1:0] vz,
    output logic             sq_valid,
    output logic [WIDTH-1:0] sq_len,
    input  logic             isq_valid,
    input  logic [WIDTH-1:0] isq,
    output logic             valid_out,
    output logic [WIDTH-1:0] nx,
    output logic [WIDTH-1:0] ny,
    output logic [WIDTH-1:0] nz,
    output logic             err
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef VEC3_NORM_SAT_EN
    localparam int SQW  = 2*WIDTH - FRAC;
    localparam int SUMW = SQW + 2;
`else
    localparam int SQW  = WIDTH;
    localparam int SUMW = WIDTH;
`endif

    logic                    accept;
    logic                    fifo_pop;
    vec3_t                   push_vec;
    vec3_t                   fifo_head;
    logic [AW:0]             fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    unused_fifo;
    logic signed [WIDTH-1:0] in_comp   [3];
    logic signed [WIDTH-1:0] head_comp [3];
    logic                    valid_s1_reg;
    logic                    sq_valid_reg;
    logic [WIDTH-1:0]        sq_len_reg;
    logic [WIDTH-1:0]        sq_len_next;
    logic [SUMW-1:0]         sq_sum;
    logic                    valid_out_reg;
    logic                    err_reg;

    assign in_ready    = !rst && (fifo_count < FIFO_DEPTH[AW:0]);
    assign accept      = valid_in && in_ready;
    assign fifo_pop    = isq_valid && !fifo_empty;
    assign unused_fifo = fifo_full;

    assign push_vec.x = $signed(vx);
    assign push_vec.y = $signed(vy);
    assign push_vec.z = $signed(vz);

    assign in_comp[0]   = $signed(vx);
    assign in_comp[1]   = $signed(vy);
    assign in_comp[2]   = $signed(vz);
    assign head_comp[0] = fifo_head.x;
    assign head_comp[1] = fifo_head.y;
    assign head_comp[2] = fifo_head.z;

    vec3_norm_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_vec),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_comp
            logic signed [2*WIDTH-1:0] sq_prod;
            logic signed [2*WIDTH-1:0] n_prod;
            logic [SQW-1:0]            sq_s1_reg;
            logic [WIDTH-1:0]          n_next;
            logic [WIDTH-1:0]          n_reg;
            logic                      unused_prod;

            assign sq_prod = (2*WIDTH)'(in_comp[gi]) * (2*WIDTH)'(in_comp[gi]);
            assign n_prod  = (2*WIDTH)'(head_comp[gi]) * (2*WIDTH)'($signed(isq));

`ifdef VEC3_NORM_SAT_EN
            // Out of range when the bits above the result's sign bit disagree with it.
            logic [WIDTH-FRAC:0] n_top;
            logic                n_ovf;
            assign n_top  = n_prod[2*WIDTH-1:FRAC+WIDTH-1];
            assign n_ovf  = !((&n_top) || !(|n_top));
            assign n_next = n_ovf ? q_sat(n_prod[2*WIDTH-1]) : n_prod[FRAC+WIDTH-1:FRAC];
            assign unused_prod = ^{sq_prod[FRAC-1:0], n_prod[FRAC-1:0]};
`else
            assign n_next = n_prod[FRAC+WIDTH-1:FRAC];
            assign unused_prod = ^{sq_prod[2*WIDTH-1:FRAC+WIDTH], sq_prod[FRAC-1:0],
                                   n_prod[2*WIDTH-1:FRAC+WIDTH], n_prod[FRAC-1:0]};
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    sq_s1_reg <= '0;
                    n_reg     <= '0;
                end else begin
                    if (accept) begin
                        sq_s1_reg <= sq_prod[FRAC+SQW-1:FRAC];
                    end
                    if (fifo_pop) begin
                        n_reg <= n_next;
                    end
                end
            end
        end
    endgenerate

    // Squares are non-negative, so zero-extension is safe for the sum.
    assign sq_sum = SUMW'(g_comp[0].sq_s1_reg) + SUMW'(g_comp[1].sq_s1_reg)
                  + SUMW'(g_comp[2].sq_s1_reg);

`ifdef VEC3_NORM_SAT_EN
    assign sq_len_next = (|sq_sum[SUMW-1:WIDTH-1]) ? Q_MAX : sq_sum[WIDTH-1:0];
`else
    assign sq_len_next = sq_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1_reg  <= 1'b0;
            sq_valid_reg  <= 1'b0;
            sq_len_reg    <= '0;
            valid_out_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            valid_s1_reg  <= accept;
            sq_valid_reg  <= valid_s1_reg;
            if (valid_s1_reg) begin
                sq_len_reg <= sq_len_next;
            end
            valid_out_reg <= fifo_pop;
            if (isq_valid && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign sq_valid  = sq_valid_reg;
    assign sq_len    = sq_len_reg;
    assign valid_out = valid_out_reg;
    assign nx        = g_comp[0].n_reg;
    assign ny        = g_comp[1].n_reg;
    assign nz        = g_comp[2].n_reg;
    assign err       = err_reg;

endmodule
